// File: rtl/fetch_bus_if.sv
// ---------------------------------------------------------------------------
// fetch_bus_if
//
// Instruction-fetch bus interface. It sits between the program counter and
// the IF pipeline register. Each fetch request goes one of two ways:
//   - a zero-wait read from the scratch-pad memory (SPM), when the top three
//     address bits select the SPM region, or
//   - an arbitrated transaction on the shared external bus:
//     request, then grant, then a one-cycle address strobe, then ready.
// While a bus word is outstanding, busy stalls the pipeline. A word that
// completes while the pipeline is stalled is parked in rd_buf_q. This lets
// the IF register capture it exactly once when the stall lifts.
//
// Ports
//   clk          clock
//   reset        asynchronous reset, active low
//   stall        pipeline stall
//   flush        pipeline flush (suppresses new accesses while in IDLE)
//   busy         access pending, stalls the pipeline
//   addr         fetch word address
//   as_          access strobe, active low
//   rw           1 = read, 0 = write
//   wr_data      write data
//   rd_data      instruction word to the IF register
//   spm_rd_data  SPM read data
//   spm_addr     SPM word address (low SPM_ADDR_W bits of addr)
//   spm_as_      SPM strobe, active low, combinational
//   spm_rw       SPM read/write
//   spm_wr_data  SPM write data
//   bus_req_     bus request, active low, registered
//   bus_grnt_    bus grant, active low
//   bus_addr     bus address, registered
//   bus_as_      bus address strobe, active low, registered
//   bus_rw       bus read/write, registered
//   bus_wr_data  bus write data, registered
//   bus_rd_data  bus read data
//   bus_rdy_     bus ready, active low
// ---------------------------------------------------------------------------
module fetch_bus_if #(
    parameter int         ADDR_W     = 30,
    parameter int         DATA_W     = 32,
    parameter int         SPM_ADDR_W = 12,
    parameter logic [2:0] SPM_REGION = 3'b011
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  busy,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  as_,
    input  logic                  rw,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     rd_data,
    input  logic [DATA_W-1:0]     spm_rd_data,
    output logic [SPM_ADDR_W-1:0] spm_addr,
    output logic                  spm_as_,
    output logic                  spm_rw,
    output logic [DATA_W-1:0]     spm_wr_data,
    output logic                  bus_req_,
    input  logic                  bus_grnt_,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic                  bus_as_,
    output logic                  bus_rw,
    output logic [DATA_W-1:0]     bus_wr_data,
    input  logic [DATA_W-1:0]     bus_rd_data,
    input  logic                  bus_rdy_
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } state_e;

    state_e              state_q,       state_d;
    logic                bus_req_q,     bus_req_d;
    logic                bus_as_q,      bus_as_d;
    logic                bus_rw_q,      bus_rw_d;
    logic [ADDR_W-1:0]   bus_addr_q,    bus_addr_d;
    logic [DATA_W-1:0]   bus_wr_data_q, bus_wr_data_d;
    logic [DATA_W-1:0]   rd_buf_q,      rd_buf_d;

    logic                request;
    logic                spm_hit;

    // A flush turns the current fetch slot into a NOP, so it masks the strobe.
    assign request = ~as_ & ~flush;
    assign spm_hit = (addr[ADDR_W-1 -: 3] == SPM_REGION);

    // The SPM address and data paths are plain wires. Only the strobe is
    // qualified, and that happens in the FSM below.
    assign spm_addr    = addr[SPM_ADDR_W-1:0];
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;

    assign bus_req_    = bus_req_q;
    assign bus_as_     = bus_as_q;
    assign bus_rw      = bus_rw_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wr_data = bus_wr_data_q;

    // State and bus-side registers. An asynchronous reset drops any
    // handshake in flight and releases the bus immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            bus_req_q     <= 1'b1;
            bus_as_q      <= 1'b1;
            bus_rw_q      <= 1'b1;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            rd_buf_q      <= '0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_as_q      <= bus_as_d;
            bus_rw_q      <= bus_rw_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_buf_q      <= rd_buf_d;
        end
    end

    // Next-state and output logic. rd_data is 0 in every slot that carries
    // no valid word. The IF register therefore sees a NOP on flushes and on
    // idle cycles.
    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_as_d      = bus_as_q;
        bus_rw_d      = bus_rw_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        rd_buf_d      = rd_buf_q;
        busy          = 1'b0;
        rd_data       = '0;
        spm_as_       = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (request) begin
                    if (spm_hit) begin
                        spm_as_ = 1'b0;
                        rd_data = spm_rd_data;
                    end else begin
                        busy          = 1'b1;
                        bus_req_d     = 1'b0;
                        bus_addr_d    = addr;
                        bus_rw_d      = rw;
                        bus_wr_data_d = wr_data;
                        state_d       = REQ;
                    end
                end
            end

            REQ: begin
                busy = 1'b1;
                if (!bus_grnt_) begin
                    bus_as_d = 1'b0;
                    state_d  = ACCESS;
                end
            end

            ACCESS: begin
                // The strobe was asserted on entry. Releasing it here
                // unconditionally keeps it exactly one cycle wide, however
                // long the slave takes to answer.
                bus_as_d = 1'b1;
                if (bus_rdy_) begin
                    busy = 1'b1;
                end else begin
                    rd_data   = bus_rd_data;
                    rd_buf_d  = bus_rd_data;
                    bus_req_d = 1'b1;
                    state_d   = stall ? STALL : IDLE;
                end
            end

            STALL: begin
                rd_data = rd_buf_q;
                if (!stall) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_bus_if.sv
// ---------------------------------------------------------------------------
// tb_fetch_bus_if
//
// Directed testbench for fetch_bus_if. Each step drives one clock cycle of
// inputs shortly after the rising edge. The outputs are then compared
// against hand-computed values before the next edge.
// ---------------------------------------------------------------------------
module tb_fetch_bus_if;

    logic        clk;
    logic        resetN;
    logic        stall;
    logic        flush;
    logic        busy;
    logic [29:0] addr;
    logic        asN;
    logic        rw;
    logic [31:0] wrData;
    logic [31:0] rdData;
    logic [31:0] spmRdData;
    logic [11:0] spmAddr;
    logic        spmAsN;
    logic        spmRw;
    logic [31:0] spmWrData;
    logic        busReqN;
    logic        busGrntN;
    logic [29:0] busAddr;
    logic        busAsN;
    logic        busRw;
    logic [31:0] busWrData;
    logic [31:0] busRdData;
    logic        busRdyN;

    int checkCount;
    int passCount;
    int busyCycles;
    int asLowCycles;

    fetch_bus_if dut (
        .clk         (clk),
        .reset       (resetN),
        .stall       (stall),
        .flush       (flush),
        .busy        (busy),
        .addr        (addr),
        .as_         (asN),
        .rw          (rw),
        .wr_data     (wrData),
        .rd_data     (rdData),
        .spm_rd_data (spmRdData),
        .spm_addr    (spmAddr),
        .spm_as_     (spmAsN),
        .spm_rw      (spmRw),
        .spm_wr_data (spmWrData),
        .bus_req_    (busReqN),
        .bus_grnt_   (busGrntN),
        .bus_addr    (busAddr),
        .bus_as_     (busAsN),
        .bus_rw      (busRw),
        .bus_wr_data (busWrData),
        .bus_rd_data (busRdData),
        .bus_rdy_    (busRdyN)
    );

    // 10 ns free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard upper bound on run time so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // One cycle of stimulus: wait for the edge, drive, then let logic settle.
    task automatic applyStimulus(input logic a, input logic [29:0] ad,
                                 input logic rwIn, input logic [31:0] wd,
                                 input logic g, input logic r,
                                 input logic s, input logic f,
                                 input logic [31:0] brd);
        @(posedge clk);
        #1;
        asN       = a;
        addr      = ad;
        rw        = rwIn;
        wrData    = wd;
        busGrntN  = g;
        busRdyN   = r;
        stall     = s;
        flush     = f;
        busRdData = brd;
        #1;
    endtask

    // Directed test sequence.
    initial begin
        checkCount = 0;
        passCount  = 0;
        resetN     = 1'b0;
        asN        = 1'b1;
        addr       = '0;
        rw         = 1'b1;
        wrData     = '0;
        busGrntN   = 1'b1;
        busRdyN    = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        busRdData  = '0;
        spmRdData  = 32'hDEADBEEF;

        // Reset values.
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rstBusReq",    32'(busReqN),   32'd1);
        checkOutput("rstBusAs",     32'(busAsN),    32'd1);
        checkOutput("rstBusRw",     32'(busRw),     32'd1);
        checkOutput("rstBusAddr",   32'(busAddr),   32'd0);
        checkOutput("rstBusWrData", busWrData,      32'd0);
        checkOutput("rstBusy",      32'(busy),      32'd0);
        checkOutput("rstRdData",    rdData,         32'd0);
        checkOutput("rstSpmAs",     32'(spmAsN),    32'd1);
        #2;
        resetN = 1'b1;

        // SPM read: same-cycle data, no busy, bus untouched.
        applyStimulus(1'b0, 30'h1800_0010, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("spmRdData", rdData,          32'hDEADBEEF);
        checkOutput("spmAddr",   32'(spmAddr),    32'h010);
        checkOutput("spmBusy",   32'(busy),       32'd0);
        checkOutput("spmBusReq", 32'(busReqN),    32'd1);
        checkOutput("spmAs",     32'(spmAsN),     32'd0);
        checkOutput("spmRw",     32'(spmRw),      32'd1);
        applyStimulus(1'b1, 30'h1800_0010, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("spmIdleAs",     32'(spmAsN),  32'd1);
        checkOutput("spmIdleRdData", rdData,       32'd0);
        checkOutput("spmIdleBusReq", 32'(busReqN), 32'd1);

        // Bus read: grant delayed 2 cycles, ready delayed 1 cycle.
        busyCycles  = 0;
        asLowCycles = 0;
        applyStimulus(1'b0, 30'h100, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("rdC0BusReq", 32'(busReqN), 32'd1);
        busyCycles += int'(busy);  asLowCycles += int'(!busAsN);
        applyStimulus(1'b0, 30'h100, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("rdC1BusReq",  32'(busReqN), 32'd0);
        checkOutput("rdC1BusAddr", 32'(busAddr), 32'h100);
        busyCycles += int'(busy);  asLowCycles += int'(!busAsN);
        applyStimulus(1'b0, 30'h100, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        busyCycles += int'(busy);  asLowCycles += int'(!busAsN);
        applyStimulus(1'b0, 30'h100, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        busyCycles += int'(busy);  asLowCycles += int'(!busAsN);
        applyStimulus(1'b0, 30'h100, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("rdC4BusAs", 32'(busAsN), 32'd0);
        busyCycles += int'(busy);  asLowCycles += int'(!busAsN);
        applyStimulus(1'b1, 30'h100, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678);
        checkOutput("rdC5RdData", rdData,         32'h12345678);
        checkOutput("rdC5Busy",   32'(busy),      32'd0);
        checkOutput("rdC5BusReq", 32'(busReqN),   32'd0);
        busyCycles += int'(busy);  asLowCycles += int'(!busAsN);
        checkOutput("rdBusyCycles", 32'(busyCycles),  32'd5);
        checkOutput("rdAsLowCycles", 32'(asLowCycles), 32'd1);
        applyStimulus(1'b1, 30'h100, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("rdDoneBusReq", 32'(busReqN), 32'd1);
        checkOutput("rdDoneRdData", rdData,       32'd0);
        checkOutput("rdDoneBusy",   32'(busy),    32'd0);

        // Bus read completing under a 3-cycle stall.
        applyStimulus(1'b0, 30'h200, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("stC0Busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 30'h200, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("stC1Busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, 30'h200, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D);
        checkOutput("stC2RdData", rdData,    32'hCAFEF00D);
        checkOutput("stC2Busy",   32'(busy), 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 30'h200, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0BAD0BAD);
            checkOutput("stHoldRdData", rdData,    32'hCAFEF00D);
            checkOutput("stHoldBusy",   32'(busy), 32'd0);
        end
        applyStimulus(1'b1, 30'h200, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0BAD0BAD);
        checkOutput("stReleaseRdData", rdData, 32'hCAFEF00D);
        applyStimulus(1'b1, 30'h200, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0BAD0BAD);
        checkOutput("stIdleRdData", rdData, 32'd0);

        // Flush in IDLE: no bus request, NOP on rd_data, SPM strobe held off.
        applyStimulus(1'b0, 30'h300, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
        checkOutput("flIdleBusy",   32'(busy), 32'd0);
        checkOutput("flIdleRdData", rdData,    32'd0);
        applyStimulus(1'b0, 30'h1800_0020, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
        checkOutput("flIdleBusReq", 32'(busReqN), 32'd1);
        checkOutput("flSpmAs",      32'(spmAsN),  32'd1);
        checkOutput("flSpmRdData",  rdData,       32'd0);

        // Flush during REQ does not abort the transaction.
        applyStimulus(1'b0, 30'h400, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 30'h400, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
        checkOutput("flReqBusy",   32'(busy),    32'd1);
        checkOutput("flReqBusReq", 32'(busReqN), 32'd0);
        applyStimulus(1'b1, 30'h400, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b1, 30'h400, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0A0B0C0D);
        checkOutput("flAccRdData", rdData,        32'h0A0B0C0D);
        checkOutput("flAccBusAs",  32'(busAsN),   32'd0);
        applyStimulus(1'b1, 30'h400, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("flDoneBusReq", 32'(busReqN), 32'd1);

        // Back-to-back: read then write starting right after completion.
        applyStimulus(1'b0, 30'h500, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 30'h500, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 30'h500, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11111111);
        checkOutput("b2bFirstRdData", rdData, 32'h11111111);
        applyStimulus(1'b0, 30'h600, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("b2bIdleBusy",   32'(busy),    32'd1);
        checkOutput("b2bIdleBusReq", 32'(busReqN), 32'd1);
        applyStimulus(1'b1, 30'h600, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("b2bBusReq",    32'(busReqN),  32'd0);
        checkOutput("b2bBusAddr",   32'(busAddr),  32'h600);
        checkOutput("b2bBusRw",     32'(busRw),    32'd0);
        checkOutput("b2bBusWrData", busWrData,     32'hA5A5A5A5);
        applyStimulus(1'b1, 30'h600, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h22222222);
        checkOutput("b2bSecondRdData", rdData, 32'h22222222);

        // Asynchronous reset in the middle of ACCESS.
        applyStimulus(1'b0, 30'h700, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 30'h700, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 30'h700, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("mrBusReqBefore", 32'(busReqN), 32'd0);
        checkOutput("mrBusAsBefore",  32'(busAsN),  32'd0);
        #1;
        resetN = 1'b0;
        #1;
        checkOutput("mrBusReq",    32'(busReqN), 32'd1);
        checkOutput("mrBusAs",     32'(busAsN),  32'd1);
        checkOutput("mrBusRw",     32'(busRw),   32'd1);
        checkOutput("mrBusAddr",   32'(busAddr), 32'd0);
        checkOutput("mrBusWrData", busWrData,    32'd0);
        checkOutput("mrBusy",      32'(busy),    32'd0);
        #2;
        resetN = 1'b1;
        applyStimulus(1'b0, 30'h800, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("mrNextBusy",   32'(busy),    32'd1);
        checkOutput("mrNextBusReq", 32'(busReqN), 32'd1);
        applyStimulus(1'b1, 30'h800, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("mrNextReqLow",  32'(busReqN), 32'd0);
        checkOutput("mrNextBusAddr", 32'(busAddr), 32'h800);
        applyStimulus(1'b1, 30'h800, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h55AA55AA);
        checkOutput("mrNextRdData", rdData, 32'h55AA55AA);
        applyStimulus(1'b1, 30'h800, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("mrNextDone", 32'(busReqN), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fetch_bus_if.md
# fetch_bus_if

Bus interface for the instruction-fetch path. It sits between the program counter and the IF pipeline register. It turns each fetch request into either a zero-wait scratch-pad (SPM) read or an arbitrated external-bus transaction. It returns the instruction word on `rd_data` and raises `busy` to stall the pipeline until the word is available. A completed bus word is held while the pipeline is stalled, so the IF register captures it exactly once.

## Interface
- `ADDR_W`, 30, word address width
- `DATA_W`, 32, word data width
- `SPM_ADDR_W`, 12, SPM word address width
- `SPM_REGION`, 3'b011, value of `addr[ADDR_W-1:ADDR_W-3]` that selects the SPM

Ports:
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-low reset
- `stall` in 1: pipeline stall
- `flush` in 1: pipeline flush
- `busy` out 1: access pending, stalls the pipeline
- `addr` in ADDR_W: fetch word address
- `as_` in 1: access strobe, active-low
- `rw` in 1: 1 = read, 0 = write
- `wr_data` in DATA_W: write data
- `rd_data` out DATA_W: read data to the IF register
- `spm_rd_data` in DATA_W: SPM read data
- `spm_addr` out SPM_ADDR_W: SPM address, equal to `addr[SPM_ADDR_W-1:0]`
- `spm_as_` out 1: SPM strobe, active-low
- `spm_rw` out 1: SPM read/write
- `spm_wr_data` out DATA_W: SPM write data
- `bus_req_` out 1: bus request, active-low
- `bus_grnt_` in 1: bus grant, active-low
- `bus_addr` out ADDR_W: bus address, registered
- `bus_as_` out 1: bus address strobe, registered
- `bus_rw` out 1: bus read/write, registered
- `bus_wr_data` out DATA_W: bus write data, registered
- `bus_rd_data` in DATA_W: bus read data
- `bus_rdy_` in 1: bus ready, active-low

## Operation
- FSM states: IDLE, REQ, ACCESS, STALL. A 32-bit `rd_buf` holds returned bus data.
- Request definition: a request exists when `as_`=0 and `flush`=0. While `flush`=1 in IDLE, no access is started, `busy`=0 and `rd_data`=0 (NOP).
- IDLE, SPM hit (region field equals `SPM_REGION`):
  - `spm_as_`=0 combinationally; `spm_rw`=`rw`.
  - `rd_data`=`spm_rd_data` in the same cycle; `busy`=0; state stays IDLE.
- IDLE, bus address:
  - `busy`=1.
  - On the next edge: `bus_req_`←0, `bus_addr`←`addr`, `bus_rw`←`rw`, `bus_wr_data`←`wr_data`, state→REQ.
- REQ:
  - `busy`=1.
  - If `bus_grnt_`=0: `bus_as_`←0, state→ACCESS. Otherwise the block waits indefinitely.
- ACCESS:
  - `bus_as_`←1 after its first cycle, so the strobe is exactly one cycle wide.
  - While `bus_rdy_`=1: `busy`=1.
  - When `bus_rdy_`=0: `busy`=0, `rd_data`=`bus_rd_data` combinationally, `rd_buf`←`bus_rd_data`, `bus_req_`←1. Next state is STALL if `stall`=1, otherwise IDLE.
- STALL: `busy`=0, `rd_data`=`rd_buf`. When `stall`=0, go to IDLE.
- Flush during REQ or ACCESS does not abort the bus transaction. The transaction completes and its data is presented normally; discarding it is the IF register's responsibility.
- `spm_as_`=1 in every state except IDLE with an SPM hit. SPM outputs carry no state.
- Reset (asynchronous, at any time, including mid-transaction):
  - state=IDLE, `bus_req_`=1, `bus_as_`=1, `bus_rw`=1, `bus_addr`=0, `bus_wr_data`=0, `rd_buf`=0.
  - A pending bus handshake is abandoned.

## Timing
- SPM fetch: 0 wait cycles; `busy` never rises.
- Bus fetch with immediate grant and immediate ready:
  - cycle 0: IDLE, `busy`=1.
  - cycle 1: REQ; grant is seen.
  - cycle 2: ACCESS with `bus_as_`=0; `bus_rdy_`=0 arrives; data is returned and `busy`=0.
  - Total: 2 busy cycles.
- Each extra cycle of grant delay or ready delay adds exactly one busy cycle.
- `bus_req_` stays low from the REQ entry edge through the edge after `bus_rdy_`=0.
- Back-to-back bus fetches: ACCESS→IDLE→REQ; the new request starts the cycle after completion.
- `rd_data` in IDLE with no request: 0.

## Test plan
- Reset mid-ACCESS (`bus_req_`=0): assert `reset`=0 → all registered outputs return to their reset values immediately; next request starts from IDLE.
- SPM read: `addr`=30'h1800_0010, `as_`=0, `spm_rd_data`=32'hDEADBEEF → same cycle `rd_data`=32'hDEADBEEF, `spm_addr`=12'h010, `busy`=0, `bus_req_`=1.
- Bus read, grant delayed 2 cycles, ready delayed 1 cycle, `addr`=30'h0000_0100, `bus_rd_data`=32'h12345678 → `busy` high for 5 cycles, `bus_as_` low for exactly 1 cycle, `bus_addr`=30'h100, `rd_data`=32'h12345678 on the ready cycle.
- Bus read completing with `stall`=1 for 3 cycles → enter STALL, `rd_data` held at the returned word for all 3 cycles with `busy`=0, IDLE on the cycle after `stall` falls.
- `flush`=1 with `as_`=0 in IDLE for a bus address → no `bus_req_`, `rd_data`=0. Flush asserted during REQ → transaction still completes, `bus_req_` released after ready.
